// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Runs the request-to-send sequence on the open-drain clock/data pads.
// The pads only ever pull low (oe=1) or release (oe=0).
// After RTS, the device generates the clock and the host shifts out a frame:
//   8 data bits (LSB first), odd parity, stop.
// The host then samples the device ack bit and waits for the bus to go idle.
// A timeout covers every device-clocked phase.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [7:0]       r_byte;
  logic             r_par;
  logic             r_nack;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_done;
  logic             r_error;
  logic             r_ready_en;
  logic             r_clk_prev;

  logic [1:0] w_pad_in;
  logic [1:0] w_sync;
  logic       w_clk_sync;
  logic       w_data_sync;
  logic       w_clk_fall;
  logic       w_timed;
  logic       w_timeout;

  // Bit 0 is the clock pad and bit 1 is the data pad.
  assign w_pad_in = {ps2_data_in, ps2_clk_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic r_s1;
      logic r_s2;
      // Two-flop synchronizer for one asynchronous pad; reset to the idle-high bus level.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s1 <= 1'b1;
          r_s2 <= 1'b1;
        end else begin
          r_s1 <= w_pad_in[gi];
          r_s2 <= r_s1;
        end
      end
      assign w_sync[gi] = r_s2;
    end
  endgenerate

  assign w_clk_sync  = w_sync[0];
  assign w_data_sync = w_sync[1];

  // Delayed copy of the synced device clock, used for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_prev <= w_clk_sync;
    end
  end

  assign w_clk_fall = r_clk_prev & ~w_clk_sync;
  assign w_timed    = (r_state == ST_SHIFT) || (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);
  assign w_timeout  = w_timed && (r_cnt == TIMEOUT_LAST);

  // Transaction sequencer: inhibit, RTS, bit shifting, ack sampling, bus-idle wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_par      <= 1'b0;
      r_nack     <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      if (w_timeout) begin
        // Timeout beats any coincident device clock edge.
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_done    <= 1'b1;
        r_error   <= 1'b1;
        r_state   <= ST_IDLE;
      end else begin
        if (w_timed) begin
          r_cnt <= r_cnt + 1'b1;
        end
        case (r_state)
          ST_IDLE: begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            if (cmd_valid && cmd_ready) begin
              r_byte   <= cmd_data;
              r_par    <= ~^cmd_data;
              r_nack   <= 1'b0;
              r_cnt    <= '0;
              r_clk_oe <= 1'b1;
              r_state  <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (r_cnt == INHIBIT_LAST) begin
              r_data_oe <= 1'b1;
              r_state   <= ST_RTS;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_RTS: begin
            // Release the clock while still holding the start bit on data.
            r_clk_oe <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_state  <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_clk_fall) begin
              if (r_bit < 4'd8) begin
                r_data_oe <= ~r_byte[r_bit[2:0]];
              end else if (r_bit == 4'd8) begin
                r_data_oe <= ~r_par;
              end else begin
                r_data_oe <= 1'b0;
                r_state   <= ST_ACK;
              end
              r_bit <= r_bit + 1'b1;
            end
          end
          ST_ACK: begin
            if (w_clk_fall) begin
              r_nack  <= w_data_sync;
              r_state <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (w_clk_sync && w_data_sync) begin
              r_done  <= 1'b1;
              r_error <= r_nack;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE) && r_ready_en;
  assign rx_inhibit  = (r_state != ST_IDLE);
  assign done        = r_done;
  assign error       = r_error;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH = 4;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       done;
  logic       error;
  logic       rx_inhibit;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  // Device-side pulls on the wired-AND bus.
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .done       (done),
    .error      (error),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard: expected error flag per completed transaction, expected frame per device frame.
  bit         exp_err_q[$];
  logic [9:0] exp_frame_q[$];

  // Device model controls: 0 ack, 1 nack, 2 never clocks, 3 ack but aborted by reset.
  int bfm_mode   = 0;
  int half       = 20;
  int bfm_falls  = 0;
  bit bfm_abort  = 1'b0;
  bit bfm_active = 1'b0;
  int frames_seen = 0;
  int done_cnt   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame as seen on the wire after each device clock rising edge:
  // bits 7:0 data (LSB first), bit 8 odd parity, bit 9 stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[7:0] = b;
    f[8]   = ((ones % 2) == 0);
    f[9]   = 1'b1;
    return f;
  endfunction

  // Monitor: pops an expectation every time the DUT signals done.
  bit mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (exp_err_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_exp = exp_err_q.pop_front();
          check("error_flag", int'(error), int'(mon_exp));
          check("pads_released_at_done", int'({ps2_clk_oe, ps2_data_oe}), 0);
          check("ready_at_done", int'(cmd_ready), 1);
          $display("txn %0d complete: error=%0d", done_cnt, error);
        end
      end else if (error) begin
        check("error_without_done", 1, 0);
      end
    end
  end

  // Device model: once the host releases the clock holding the start bit, clock out 11 pulses.
  logic [9:0] got;
  int         h;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !ps2_clk_oe && ps2_data_oe && bfm_mode != 2) begin
        bfm_active = 1'b1;
        h = half;
        got = '0;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 11 && !bfm_abort; i++) begin
          if (i == 11 && bfm_mode == 0) dev_data_low = 1'b1;
          dev_clk_low = 1'b1;
          bfm_falls = i;
          repeat (h) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (h) @(negedge clk);
          if (i <= 10) got[i-1] = ps2_data_in;
        end
        dev_data_low = 1'b0;
        dev_clk_low  = 1'b0;
        if (!bfm_abort) begin
          frames_seen++;
          if (exp_frame_q.size() == 0) check("unexpected_frame", 1, 0);
          else check("frame_bits", int'(got), int'(exp_frame_q.pop_front()));
        end
        bfm_active = 1'b0;
      end
    end
  end

  task automatic wait_bfm_idle();
    int n;
    n = 0;
    while (bfm_active && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("device_model_idle", int'(bfm_active), 0);
  endtask

  task automatic send(input logic [7:0] b, input int mode, input bit hold);
    int n;
    bit bad;
    bit got_done;
    int frames0;
    bfm_mode  = mode;
    half      = int'($urandom_range(15, 25));
    bfm_falls = 0;
    frames0   = frames_seen;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", int'(cmd_ready), 1);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    if (mode <= 1) begin
      exp_err_q.push_back(mode == 1);
      exp_frame_q.push_back(frame_of(b));
    end else if (mode == 2) begin
      exp_err_q.push_back(1'b1);
    end
    $display("txn send 0x%02h mode=%0d half=%0d", b, mode, half);
    @(negedge clk);
    if (hold) cmd_data = 8'hAA;
    else cmd_valid = 1'b0;
    bad = 1'b0;
    for (int j = 0; j < INH; j++) begin
      check("inhibit_pads", int'({ps2_clk_oe, ps2_data_oe}), 2);
      if (!rx_inhibit || cmd_ready) bad = 1'b1;
      @(negedge clk);
    end
    check("rts_pads", int'({ps2_clk_oe, ps2_data_oe}), 3);
    @(negedge clk);
    check("shift_start_pads", int'({ps2_clk_oe, ps2_data_oe}), 1);
    if (mode == 3) begin
      n = 0;
      while (bfm_falls < 4 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("reached_bit3", int'(bfm_falls >= 4), 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      bfm_abort = 1'b1;
      @(negedge clk);
      check("reset_pads_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
      check("reset_no_done", int'(done), 0);
      check("reset_ready_low", int'(cmd_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_bfm_idle();
      bfm_abort = 1'b0;
      check("ready_after_reset", int'(cmd_ready), 1);
      return;
    end
    n = 1;
    got_done = 1'b0;
    while (n < 3000) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!rx_inhibit || cmd_ready) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (hold) cmd_valid = 1'b0;
    check("done_seen", int'(got_done), 1);
    check("busy_flags", int'(bad), 0);
    if (mode == 2) check("timeout_latency", n, TMO + 1);
    wait_bfm_idle();
    if (mode <= 1) check("frames_per_accept", frames_seen - frames0, 1);
    if (hold) begin
      @(negedge clk);
      check("held_request_ignored", int'(rx_inhibit), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] rb;
  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", int'({cmd_ready, done, error, rx_inhibit, ps2_clk_oe, ps2_data_oe}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", int'(cmd_ready), 1);

    send(8'hF4, 0, 1'b0);
    send(8'hFF, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'h5A, 1, 1'b0);
    send(8'h3C, 2, 1'b0);
    send(8'hF4, 3, 1'b0);
    send(8'hF4, 0, 1'b0);
    send(8'hF4, 0, 1'b1);
    for (int t = 0; t < 10; t++) begin
      rb = 8'($urandom);
      send(rb, int'($urandom_range(0, 1)), 1'b0);
    end

    repeat (20) @(negedge clk);
    check("pending_done_expectations", exp_err_q.size(), 0);
    check("pending_frame_expectations", exp_frame_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
